// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Purpose:
//   Turns single-cycle event pulses into level windows of programmable width.
//   An accepted trigger raises level_out on the next cycle and holds it high
//   for L cycles, where L = len, or 1 when len is 0. An optional hold-off
//   period of forced idle cycles can follow each completed window. Triggers
//   that cannot be honoured are counted in a saturating 8-bit drop counter.
//
// Parameters:
//   CNT_W     width of len and of the window counter
//   HOLDOFF   idle cycles forced after each completed window (0 = none)
//   RETRIGGER 0: triggers during a window are dropped
//             1: a trigger during a window reloads it with the new length
//
// Ports:
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   trig       event pulse, sampled on every rising edge
//   len        window length, sampled only when a trigger is accepted
//   clr_drop   synchronous clear of drop_cnt
//   level_out  stretched level (registered)
//   busy       high while a window or hold-off is in progress (registered)
//   done       one-cycle pulse on the cycle after a window's last cycle
//   drop_cnt   number of rejected triggers, saturating at 255
// -----------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int CNT_W     = 8,
  parameter int HOLDOFF   = 0,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  input  logic             clr_drop,
  output logic             level_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // The hold-off counter needs at least one bit even when hold-off is unused.
  localparam int              HO_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);
  localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [HO_W-1:0]  hcnt_reg, hcnt_next;
  logic             level_reg, level_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [7:0]       drop_reg, drop_next;

  logic [CNT_W-1:0] eff_len;
  logic             last_cycle;
  logic             drop_evt;

  // A zero length still produces a one-cycle window.
  assign eff_len    = (len == '0) ? CNT_ONE : len;
  // cnt_reg holds the number of active cycles remaining, including this one.
  assign last_cycle = (cnt_reg == CNT_ONE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      hcnt_reg  <= '0;
      level_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      drop_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hcnt_reg  <= hcnt_next;
      level_reg <= level_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      drop_reg  <= drop_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hcnt_next  = hcnt_reg;
    done_next  = 1'b0;
    drop_evt   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (trig) begin
          state_next = ST_ACTIVE;
          cnt_next   = eff_len;
        end
      end

      ST_ACTIVE: begin
        if (last_cycle) begin
          // The window completes regardless of what happens next.
          done_next = 1'b1;
          if (HOLDOFF > 0) begin
            state_next = ST_HOLDOFF;
            hcnt_next  = HO_LOAD;
            cnt_next   = '0;
            // No window can start during the hold-off that follows.
            drop_evt   = trig;
          end else if (trig) begin
            // Back-to-back: a new window starts with no gap in level_out.
            cnt_next = eff_len;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
          if (trig) begin
            if (RETRIGGER != 0) begin
              cnt_next = eff_len;
            end else begin
              drop_evt = 1'b1;
            end
          end
        end
      end

      ST_HOLDOFF: begin
        drop_evt = trig;
        if (hcnt_reg == HO_ONE) begin
          state_next = ST_IDLE;
          hcnt_next  = '0;
        end else begin
          hcnt_next = hcnt_reg - HO_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        hcnt_next  = '0;
      end
    endcase

    // Level and busy are decoded from the next state so they register
    // alongside it.
    level_next = (state_next == ST_ACTIVE);
    busy_next  = (state_next != ST_IDLE);

    // A clear coinciding with a drop leaves exactly that one drop counted.
    if (clr_drop) begin
      drop_next = drop_evt ? 8'd1 : 8'd0;
    end else if (drop_evt && (drop_reg != 8'hFF)) begin
      drop_next = drop_reg + 8'd1;
    end else begin
      drop_next = drop_reg;
    end
  end

  assign level_out = level_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Three instances: u0 (no hold-off, triggers dropped), u1 (retrigger),
// u2 (hold-off of 3). Each step drives one instance's trigger, queues the
// expected outputs for the following cycle and compares them after the edge.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  typedef struct {
    int         sel;
    logic       trig;
    logic [7:0] len;
    logic       clr;
    logic [3:0] mask;   // {level, busy, done, drop} comparisons enabled
    logic       lvl;
    logic       bsy;
    logic       dn;
    logic [7:0] drop;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] trig;
  logic [7:0] len;
  logic       clr;
  logic [2:0] lvl;
  logic [2:0] bsy;
  logic [2:0] dn;
  logic [7:0] drp [3];

  int tests_run    = 0;
  int tests_failed = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  pulse_stretcher #(.CNT_W(8), .HOLDOFF(0), .RETRIGGER(0)) u0 (
    .clk(clk), .rst_n(rst_n), .trig(trig[0]), .len(len), .clr_drop(clr),
    .level_out(lvl[0]), .busy(bsy[0]), .done(dn[0]), .drop_cnt(drp[0]));

  pulse_stretcher #(.CNT_W(8), .HOLDOFF(0), .RETRIGGER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .trig(trig[1]), .len(len), .clr_drop(clr),
    .level_out(lvl[1]), .busy(bsy[1]), .done(dn[1]), .drop_cnt(drp[1]));

  pulse_stretcher #(.CNT_W(8), .HOLDOFF(3), .RETRIGGER(0)) u2 (
    .clk(clk), .rst_n(rst_n), .trig(trig[2]), .len(len), .clr_drop(clr),
    .level_out(lvl[2]), .busy(bsy[2]), .done(dn[2]), .drop_cnt(drp[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Table row: inputs for one cycle and the outputs expected on the next.
  function automatic void add(input int sel, input logic t, input int l,
                              input logic c, input logic el, input logic eb,
                              input logic ed, input int edrop);
    vec_t v;
    v.sel = sel; v.trig = t; v.len = 8'(l); v.clr = c; v.mask = 4'hF;
    v.lvl = el; v.bsy = eb; v.dn = ed; v.drop = 8'(edrop);
    tbl.push_back(v);
  endfunction

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    trig = 3'b000;
    trig[v.sel] = v.trig;
    len = v.len;
    clr = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("[TB] %s u%0d trig=%0b len=%0d clr=%0b -> level=%0b busy=%0b done=%0b drop=%0d",
             tag, e.sel, e.trig, e.len, e.clr, lvl[e.sel], bsy[e.sel], dn[e.sel], drp[e.sel]);
    if (e.mask[3]) check({tag, " level"}, int'(lvl[e.sel]), int'(e.lvl));
    if (e.mask[2]) check({tag, " busy"},  int'(bsy[e.sel]), int'(e.bsy));
    if (e.mask[1]) check({tag, " done"},  int'(dn[e.sel]),  int'(e.dn));
    if (e.mask[0]) check({tag, " drop"},  int'(drp[e.sel]), int'(e.drop));
  endtask

  initial begin
    vec_t v;
    int   nd;
    int   saw_bad;

    trig = 3'b000; len = 8'd0; clr = 1'b0; rst_n = 1'b0;

    // ---- Tables -------------------------------------------------------------
    // A: len=5 trig at cycle 0 -> level 1..5, done at 6. Later len changes ignored.
    add(0,0,7,1, 0,0,0,0);
    add(0,1,5,0, 1,1,0,0);
    for (int i = 1; i <= 4; i++) add(0,0,9,0, 1,1,0,0);
    add(0,0,9,0, 0,0,1,0);
    add(0,0,9,0, 0,0,0,0);
    // B: len=0 -> one-cycle window.
    add(0,1,0,0, 1,1,0,0);
    add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 0,0,0,0);
    // C: drop mode, len=10, trig at 0, 3, 7.
    add(0,0,0,1, 0,0,0,0);
    add(0,1,10,0, 1,1,0,0);
    add(0,0,10,0, 1,1,0,0);
    add(0,0,10,0, 1,1,0,0);
    add(0,1,10,0, 1,1,0,1);
    for (int i = 4; i <= 6; i++) add(0,0,10,0, 1,1,0,1);
    add(0,1,10,0, 1,1,0,2);
    add(0,0,10,0, 1,1,0,2);
    add(0,0,10,0, 1,1,0,2);
    add(0,0,10,0, 0,0,1,2);
    add(0,0,10,0, 0,0,0,2);
    // D: retrigger mode, len=10 at 0, len=4 at 5 -> level 1..9, done at 10.
    add(1,0,0,1, 0,0,0,0);
    add(1,1,10,0, 1,1,0,0);
    for (int i = 1; i <= 4; i++) add(1,0,10,0, 1,1,0,0);
    add(1,1,4,0, 1,1,0,0);
    for (int i = 6; i <= 8; i++) add(1,0,10,0, 1,1,0,0);
    add(1,0,10,0, 0,0,1,0);
    add(1,0,10,0, 0,0,0,0);
    // E: hold-off 3, len=2, trig at 0 and 4.
    add(2,0,0,1, 0,0,0,0);
    add(2,1,2,0, 1,1,0,0);
    add(2,0,2,0, 1,1,0,0);
    add(2,0,2,0, 0,1,1,0);
    add(2,0,2,0, 0,1,0,0);
    add(2,1,2,0, 0,1,0,1);
    add(2,0,2,0, 0,0,0,1);
    add(2,0,2,0, 0,0,0,1);
    // F: back-to-back, len=2, trig at 0 and 2 -> level 1..4, done at 3 and 5.
    add(0,0,0,1, 0,0,0,0);
    add(0,1,2,0, 1,1,0,0);
    add(0,0,2,0, 1,1,0,0);
    add(0,1,2,0, 1,1,1,0);
    add(0,0,2,0, 1,1,0,0);
    add(0,0,2,0, 0,0,1,0);
    add(0,0,2,0, 0,0,0,0);

    // ---- Reset state (asserted asynchronously, no edge needed) -------------
    #3;
    for (int k = 0; k < 3; k++) begin
      check("reset level", int'(lvl[k]), 0);
      check("reset busy",  int'(bsy[k]), 0);
      check("reset done",  int'(dn[k]),  0);
      check("reset drop",  int'(drp[k]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // ---- Saturation: len=255 window with trig held every cycle -------------
    // Drops on cycles 1..254 and 256.., cycle 255 is a back-to-back accept.
    nd = 0;
    for (int i = 0; i <= 301; i++) begin
      if (i >= 1 && i != 255) nd++;
      v.sel = 0; v.trig = 1'b1; v.len = 8'd255; v.clr = 1'b0; v.mask = 4'hF;
      v.lvl = 1'b1; v.bsy = 1'b1; v.dn = (i == 255);
      v.drop = (nd > 255) ? 8'd255 : 8'(nd);
      step(v, $sformatf("sat%0d", i));
    end

    // Clear together with a drop -> 1, then clear alone -> 0.
    v.sel = 0; v.trig = 1'b1; v.len = 8'd3; v.clr = 1'b1; v.mask = 4'hF;
    v.lvl = 1'b1; v.bsy = 1'b1; v.dn = 1'b0; v.drop = 8'd1;
    step(v, "clr_with_drop");
    v.trig = 1'b0; v.drop = 8'd0;
    step(v, "clr_alone");
    v.clr = 1'b0;
    step(v, "still_active");

    // ---- Reset mid-window: outputs drop immediately, no done afterwards ----
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst level", int'(lvl[0]), 0);
    check("async rst busy",  int'(bsy[0]), 0);
    check("async rst done",  int'(dn[0]),  0);
    check("async rst drop",  int'(drp[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (dn[0] || lvl[0] || bsy[0]) saw_bad++;
    end
    check("post-reset quiet cycles", saw_bad, 0);
    check("scoreboard empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Converts single-cycle event pulses, such as those from the edge-detect front end, back into level windows of programmable width. Each accepted trigger drives level_out high for a programmed number of cycles. An optional hold-off period follows each window. Triggers that cannot be honoured are counted so software can see lost events.

Parameters:
CNT_W, 8, width of the len input and of the internal window counter.
HOLDOFF, 0, number of idle cycles forced after each completed window (0 = none).
RETRIGGER, 0, retrigger policy: 0 = triggers while active are dropped; 1 = a trigger while active restarts the window.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
trig  in  1  event pulse, sampled every rising clk edge
len  in  CNT_W  window length in cycles, sampled only when a trigger is accepted
clr_drop  in  1  synchronous clear of drop_cnt
level_out  out  1  stretched level output, registered
busy  out  1  high in ACTIVE or HOLDOFF
done  out  1  one-cycle pulse marking completion of a window
drop_cnt  out  8  count of rejected triggers, saturates at 255

Behaviour:
- Reset (asynchronous, any state): state=IDLE; level_out=0, busy=0, done=0, drop_cnt=0, counters=0. A window in progress is abandoned with no done pulse.
- Effective length L = len, except len==0 is treated as L=1. L is captured in the cycle the trigger is accepted.
- States: IDLE, ACTIVE, HOLDOFF. All outputs are registered.
- IDLE: trig=1 -> ACTIVE. level_out is high from the next cycle and stays high for exactly L cycles.
- ACTIVE: the counter decrements each cycle. On the final active cycle:
  - HOLDOFF>0 -> HOLDOFF.
  - HOLDOFF==0 -> IDLE, unless trig=1 in that same cycle (see back-to-back rule).
- done=1 for exactly one cycle: the first cycle after the final active cycle.
- HOLDOFF: level_out=0 and busy=1 for exactly HOLDOFF cycles, then IDLE. Triggers in HOLDOFF are dropped in both RETRIGGER modes.
- Back-to-back (HOLDOFF==0): trig in the final active cycle is accepted as a new window.
  - level_out stays continuously high; new len is captured.
  - done still pulses for the completed window.
  - The trigger is not counted as a drop.
- Trig in ACTIVE, not the final cycle, RETRIGGER=0: ignored, drop_cnt increments.
- Trig in ACTIVE, not the final cycle, RETRIGGER=1: counter reloads with the new L. The window runs L cycles from the next cycle. No done for the abandoned window, no drop counted.
- drop_cnt update rules:
  - Saturates at 255; further drops leave it at 255.
  - clr_drop=1 alone -> 0 next cycle.
  - clr_drop and a drop in the same cycle -> 1.
- len changes while not accepting a trigger have no effect on a running window.
- busy = (state != IDLE), registered together with the state.

Test Plan:
- Reset, then trig for 1 cycle with len=5 at cycle 0 -> level_out high cycles 1..5, done=1 at cycle 6, busy low at cycle 6, drop_cnt=0.
- len=0, single trig -> level_out high for exactly 1 cycle, done on the following cycle.
- RETRIGGER=0, len=10, trig at cycles 0, 3, 7 -> window at cycles 1..10 unchanged, drop_cnt=2, one done pulse at cycle 11.
- RETRIGGER=1, len=10, trig at cycle 0, then trig with len=4 at cycle 5 -> level_out high cycles 1..9, single done at cycle 10, drop_cnt=0.
- HOLDOFF=3, len=2, trig at cycle 0 and again at cycle 4 -> level high cycles 1..2, busy through cycle 5, cycle-4 trig dropped (drop_cnt=1). With HOLDOFF=0, trig at cycle 2 (final active cycle) -> level_out continuous cycles 1..4, done pulses at cycle 3 and cycle 5.
- Drive 300 drops -> drop_cnt=255. Assert clr_drop together with a drop -> drop_cnt=1. Assert rst_n=0 mid-window -> level_out, busy and done are 0 immediately (asynchronously), and no done pulse follows.
